// File: rtl/seq_alu.sv
// Registered saturating ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to add opcode 1111 as an iterative restoring signed divide.
module seq_alu #(
    parameter int WIDTH    = 11,
    parameter int LIMIT    = 999,
    parameter int TRUE_VAL = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             illegal,
    output logic             gr_flag,
    output logic             lt_flag,
    output logic             eq_flag
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]     LIM_POS = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0]     LIM_NEG = WIDTH'(-LIMIT);
    localparam logic [WIDTH-1:0]     TRUE_W  = WIDTH'(TRUE_VAL);
    localparam logic signed [AW-1:0] LIM_HI  = AW'(LIMIT);
    localparam logic signed [AW-1:0] LIM_LO  = -LIM_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
`ifdef SEQ_ALU_DIV_EN
        , S_DIV
`endif
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'b1000,
        OP_SUB = 4'b1001,
        OP_MUL = 4'b1010,
        OP_NOT = 4'b1011,
        OP_TEQ = 4'b1100,
        OP_TGT = 4'b1101,
        OP_TLT = 4'b1110,
        OP_DIV = 4'b1111
    } opcode_t;

    state_t                 state;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     mcand;
    logic [WIDTH:0]         mplier;
    logic [CW-1:0]          cnt;
    logic                   sign_q;

    logic                   a_gt, a_lt, a_eq;
    logic [WIDTH:0]         mag_a, mag_b;
    logic [WIDTH:0]         sat_add, sat_sub, sat_mul;
    logic [2*WIDTH-1:0]     acc_step;

    function automatic logic signed [AW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(AW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Magnitude is one bit wider so that -2^(WIDTH-1) does not wrap.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -e : e;
    endfunction

    function automatic logic signed [AW-1:0] apply_sign(input logic s, input logic [AW-2:0] m);
        return s ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // Returns {overflow, clamped value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [AW-1:0] r);
        if (r > LIM_HI)
            return {1'b1, LIM_POS};
        else if (r < LIM_LO)
            return {1'b1, LIM_NEG};
        else
            return {1'b0, r[WIDTH-1:0]};
    endfunction

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0] rem_sh, rem_next, quot_next, sat_div;
    logic           fits;
`endif

    always_comb begin
        a_gt     = $signed(in0) > $signed(in1);
        a_lt     = $signed(in0) < $signed(in1);
        a_eq     = in0 == in1;
        mag_a    = magnitude(in0);
        mag_b    = magnitude(in1);
        sat_add  = saturate(sext(in0) + sext(in1));
        sat_sub  = saturate(sext(in0) - sext(in1));
        acc_step = acc + (mplier[0] ? mcand : '0);
        sat_mul  = saturate(apply_sign(sign_q, acc_step));
`ifdef SEQ_ALU_DIV_EN
        // Divide reuses acc as remainder, mplier as dividend/quotient shifter, mcand as divisor.
        rem_sh    = {acc[WIDTH-1:0], mplier[WIDTH-1]};
        fits      = rem_sh >= mcand[WIDTH:0];
        rem_next  = fits ? rem_sh - mcand[WIDTH:0] : rem_sh;
        quot_next = {mplier[WIDTH-1:0], fits};
        sat_div   = saturate(apply_sign(sign_q, {{WIDTH{1'b0}}, quot_next[WIDTH-1:0]}));
`endif
    end

    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            out      <= '0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            gr_flag  <= 1'b0;
            lt_flag  <= 1'b0;
            eq_flag  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        {overflow, out} <= sat_mul;
                        illegal         <= 1'b0;
                        cnt             <= '0;
                        state           <= S_DONE;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    acc    <= {{(WIDTH-1){1'b0}}, rem_next};
                    mplier <= quot_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        {overflow, out} <= sat_div;
                        illegal         <= 1'b0;
                        cnt             <= '0;
                        state           <= S_DONE;
                    end
                end
`endif
                default: begin
                    if (in_valid && in_ready) begin
                        gr_flag  <= a_gt;
                        lt_flag  <= a_lt;
                        eq_flag  <= a_eq;
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                        state    <= S_DONE;
                        case (funct)
                            OP_ADD: {overflow, out} <= sat_add;
                            OP_SUB: {overflow, out} <= sat_sub;
                            OP_MUL: begin
                                sign_q <= in0[WIDTH-1] ^ in1[WIDTH-1];
                                mcand  <= {{(WIDTH-1){1'b0}}, mag_a};
                                mplier <= mag_b;
                                acc    <= '0;
                                cnt    <= '0;
                                state  <= S_MUL;
                            end
                            OP_NOT: out <= (in0 == '0) ? TRUE_W : '0;
                            OP_TEQ: out <= a_eq ? TRUE_W : '0;
                            OP_TGT: out <= a_gt ? TRUE_W : '0;
                            OP_TLT: out <= a_lt ? TRUE_W : '0;
`ifdef SEQ_ALU_DIV_EN
                            OP_DIV: begin
                                if (in1 == '0) begin
                                    out      <= '0;
                                    overflow <= 1'b1;
                                end else begin
                                    sign_q <= in0[WIDTH-1] ^ in1[WIDTH-1];
                                    mcand  <= {{(WIDTH-1){1'b0}}, mag_b};
                                    mplier <= mag_a;
                                    acc    <= '0;
                                    cnt    <= '0;
                                    state  <= S_DIV;
                                end
                            end
`endif
                            default: begin
                                out      <= '0;
                                overflow <= 1'b1;
                                illegal  <= 1'b1;
                            end
                        endcase
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: handshake timing, saturation, multiply latency, back-pressure, reset.
module tb_seq_alu;

    localparam int W = 11;
    localparam logic [3:0] F_ADD = 4'b1000;
    localparam logic [3:0] F_SUB = 4'b1001;
    localparam logic [3:0] F_MUL = 4'b1010;
    localparam logic [3:0] F_NOT = 4'b1011;
    localparam logic [3:0] F_TEQ = 4'b1100;
    localparam logic [3:0] F_TGT = 4'b1101;
    localparam logic [3:0] F_DIV = 4'b1111;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   funct = '0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         overflow, illegal, gr_flag, lt_flag, eq_flag;

    int total = 0;
    int bad = 0;

    seq_alu #(.WIDTH(W), .LIMIT(999), .TRUE_VAL(100)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow),
        .illegal   (illegal),
        .gr_flag   (gr_flag),
        .lt_flag   (lt_flag),
        .eq_flag   (eq_flag)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] f, input int a, input int b);
        funct    = f;
        in0      = W'(a);
        in1      = W'(b);
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [3:0] f, input int a, input int b);
        drive(f, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out, overflow, illegal, gr_flag, lt_flag, eq_flag} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got out=%0d ovf=%b ill=%b gr=%b lt=%b eq=%b want all 0",
                     out, overflow, illegal, gr_flag, lt_flag, eq_flag);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL add_pre_valid: got %b want 0", out_valid);
        end
        issue(F_ADD, 300, 400);
        total++;
        if (out_valid !== 1'b1 || out !== W'(700) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL add_300_400: got v=%b out=%0d ovf=%b want v=1 out=700 ovf=0",
                     out_valid, $signed(out), overflow);
        end
        issue(F_ADD, 900, 200);
        total++;
        if (out !== W'(999) || overflow !== 1'b1) begin
            bad++;
            $display("FAIL add_sat_hi: got out=%0d ovf=%b want 999 1", $signed(out), overflow);
        end
        issue(F_SUB, -900, 500);
        total++;
        if (out !== W'(-999) || overflow !== 1'b1 || lt_flag !== 1'b1) begin
            bad++;
            $display("FAIL sub_sat_lo: got out=%0d ovf=%b lt=%b want -999 1 1",
                     $signed(out), overflow, lt_flag);
        end
        drain();
    endtask

    task automatic test_mul();
        issue(F_MUL, -25, -30);
        for (int i = 0; i < 11; i++) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL mul_busy_%0d: got v=%b rdy=%b want 0 0", i, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        total++;
        if (out_valid !== 1'b1 || out !== W'(750) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL mul_750: got v=%b out=%0d ovf=%b want 1 750 0",
                     out_valid, $signed(out), overflow);
        end
        issue(F_MUL, 100, -20);
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(-999) || overflow !== 1'b1) begin
            bad++;
            $display("FAIL mul_sat_neg: got v=%b out=%0d ovf=%b want 1 -999 1",
                     out_valid, $signed(out), overflow);
        end
        issue(F_MUL, -1024, 1);
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(-999) || overflow !== 1'b1 || lt_flag !== 1'b1) begin
            bad++;
            $display("FAIL mul_minint: got v=%b out=%0d ovf=%b lt=%b want 1 -999 1 1",
                     out_valid, $signed(out), overflow, lt_flag);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(F_ADD, 1, 2);
        drive(F_TGT, 5, 3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out !== W'(3) || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: got v=%b out=%0d rdy=%b want 1 3 0",
                         i, out_valid, $signed(out), in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(100) || gr_flag !== 1'b1) begin
            bad++;
            $display("FAIL b2b_tgt: got v=%b out=%0d gr=%b want 1 100 1",
                     out_valid, $signed(out), gr_flag);
        end
        drive(F_NOT, 0, 9);
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(100) || lt_flag !== 1'b1) begin
            bad++;
            $display("FAIL b2b_not: got v=%b out=%0d lt=%b want 1 100 1",
                     out_valid, $signed(out), lt_flag);
        end
        drive(F_TEQ, 4, 7);
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(0) || eq_flag !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_teq: got v=%b out=%0d eq=%b ovf=%b want 1 0 0 0",
                     out_valid, $signed(out), eq_flag, overflow);
        end
        drain();
    endtask

    task automatic test_illegal();
        issue(4'b0000, 5, 5);
        total++;
        if (out !== W'(0) || overflow !== 1'b1 || illegal !== 1'b1 || eq_flag !== 1'b1) begin
            bad++;
            $display("FAIL illegal_0000: got out=%0d ovf=%b ill=%b eq=%b want 0 1 1 1",
                     $signed(out), overflow, illegal, eq_flag);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        logic saw_valid;
        issue(F_MUL, 7, 9);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(F_ADD, 50, 50);
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || out !== W'(0) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_reset: got v=%b out=%0d rdy=%b want 0 0 1",
                     out_valid, $signed(out), in_ready);
        end
        in_valid  = 1'b0;
        reset_n   = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0) begin
            bad++; $display("FAIL mul_discarded: got out_valid seen=%b want 0", saw_valid);
        end
        issue(F_ADD, 1, 1);
        total++;
        if (out_valid !== 1'b1 || out !== W'(2) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL add_after_reset: got v=%b out=%0d ovf=%b want 1 2 0",
                     out_valid, $signed(out), overflow);
        end
        drain();
    endtask

    task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
        issue(F_DIV, -7, 2);
        repeat (11) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out !== W'(-3) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL div_m7_2: got v=%b out=%0d ovf=%b want 1 -3 0",
                     out_valid, $signed(out), overflow);
        end
        issue(F_DIV, 5, 0);
        total++;
        if (out_valid !== 1'b1 || out !== W'(0) || overflow !== 1'b1 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL div_by_zero: got v=%b out=%0d ovf=%b ill=%b want 1 0 1 0",
                     out_valid, $signed(out), overflow, illegal);
        end
`else
        issue(F_DIV, 5, 2);
        total++;
        if (out_valid !== 1'b1 || out !== W'(0) || overflow !== 1'b1 || illegal !== 1'b1) begin
            bad++;
            $display("FAIL op1111_illegal: got v=%b out=%0d ovf=%b ill=%b want 1 0 1 1",
                     out_valid, $signed(out), overflow, illegal);
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
        test_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 11-bit ALU.
- Executes one operation per transaction using a valid/ready handshake on both the operand side and the result side.
- Add, sub, logical-not and compares complete in 1 cycle; multiply is an iterative shift-add taking WIDTH cycles.
- Results saturate to the game range [-LIMIT, +LIMIT]. Sits between the instruction decoder and the register file in the core datapath.

Parameters:
- WIDTH, 11: operand/result width, two's complement.
- LIMIT, 999: saturation magnitude; must satisfy LIMIT <= 2^(WIDTH-1)-1.
- TRUE_VAL, 100: value produced by NOT and the compare ops when true.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and funct are presented.
- in_ready  out  1  block can accept an operation.
- funct  in  4  opcode (encoding under Behaviour).
- in0  in  WIDTH  signed operand A.
- in1  in  WIDTH  signed operand B.
- out_valid  out  1  result registers are valid.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  signed, saturated result.
- overflow  out  1  true result fell outside [-LIMIT, LIMIT], or the op was illegal/degenerate.
- illegal  out  1  funct was not a supported opcode.
- gr_flag  out  1  in0 > in1, signed; registered with the result.
- lt_flag  out  1  in0 < in1, signed; registered with the result.
- eq_flag  out  1  in0 == in1; registered with the result.

Behaviour:
- Opcodes: 1000 ADD, 1001 SUB, 1010 MUL, 1011 NOT, 1100 TEQ, 1101 TGT, 1110 TLT. Any other code is illegal.
- Reset: reset_n sampled low at a clock edge forces:
  - state to IDLE;
  - out, overflow, illegal and all flags to 0;
  - out_valid to 0;
  - the multiplier accumulator and counter to 0.
  An in-flight MUL is discarded. in_valid is ignored on any cycle where reset_n is low.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, out_valid=0; iterative multiply in progress.
  - DONE: out_valid=1; in_ready=out_ready.
- Handshake: the operation is accepted on a rising edge where in_valid && in_ready. The result is consumed on a rising edge where out_valid && out_ready. All outputs hold stable in DONE until consumed.
- Single-cycle ops (accepted from IDLE or from DONE):
  - On acceptance, the result, flags, overflow and illegal are registered and the state goes to DONE.
  - Latency is 1: out_valid rises the cycle after acceptance.
  - If accepted from DONE while the previous result is consumed on the same edge, the new result replaces it with no bubble, giving 1 op/cycle throughput.
- MUL:
  - On acceptance, register the sign (in0[msb]^in1[msb]) and the magnitudes |in0| and |in1|, and go to MUL.
  - Each cycle in MUL performs one shift-add step on a 2*WIDTH accumulator.
  - After WIDTH steps, apply the sign, saturate, register the result and go to DONE.
  - Latency is WIDTH+1 cycles from acceptance to out_valid (12 at the default width).
  - The most negative input (-2^(WIDTH-1)) has its magnitude computed in WIDTH+1 bits and must not wrap.
- Arithmetic width and saturation:
  - ADD and SUB are computed at WIDTH+1 bits, so no wrap is possible.
  - For every arithmetic result R: if R > LIMIT then out=LIMIT and overflow=1; if R < -LIMIT then out=-LIMIT and overflow=1; otherwise out=R and overflow=0.
  - The effect of operands already outside the range is covered by the R check; they are not pre-clamped.
- NOT: out=TRUE_VAL if in0==0, else 0; overflow=0.
- TEQ/TGT/TLT: out=TRUE_VAL if the relation holds, else 0; overflow=0.
- Flags: gr_flag/lt_flag/eq_flag are computed from the operands for every op, including MUL and illegal ops.
- Illegal funct: takes the 1-cycle path with out=0, overflow=1, illegal=1.
- Simultaneous events:
  - Reset takes priority over all handshakes.
  - In DONE with out_ready=0, in_valid is held off because in_ready=0.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN
- When defined, opcode 1111 is DIV: signed quotient truncated toward zero.
  - Computed by restoring division over WIDTH iterations in a DIV state.
  - Latency WIDTH+1, with the result saturated as above.
  - in1==0: 1-cycle path with out=0, overflow=1, illegal=0.
- When not defined, 1111 is illegal and no divider logic is synthesised.

Test Plan:
- Reset and ADD: hold reset_n low 2 cycles, then check all outputs are 0 and in_ready=1. ADD 300+400 → out=700, overflow=0 exactly 1 cycle after acceptance.
- Add saturation: ADD 900+200 → out=999, overflow=1. SUB -900-500 → out=-999, overflow=1, lt_flag=1.
- MUL: MUL -25×-30 → out=750, overflow=0, out_valid exactly 12 cycles after acceptance, in_ready=0 during MUL. MUL 100×-20 → out=-999, overflow=1. MUL -1024×1 → out=-999, overflow=1.
- Back-pressure and throughput: hold out_ready=0 after ADD 1+2 → out holds 3 and in_ready=0. Then assert out_ready with back-to-back TGT 5,3 / NOT 0 / TEQ 4,7 → outputs 100, 100, 0 on consecutive cycles, with gr_flag=1 on the first.
- Illegal op and reset mid-MUL: funct 0000 → out=0, overflow=1, illegal=1. Assert reset_n low on cycle 5 of a MUL → out_valid stays 0 and the next ADD 1+1 returns 2.
- Divide (with SEQ_ALU_DIV_EN): DIV -7/2 → out=-3. DIV 5/0 → out=0, overflow=1 after 1 cycle. Without the macro, funct 1111 → illegal=1.
